fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and address width (>=29).
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-003 SHALL have parameter DEPTH, default 2, output queue entries and max outstanding requests (power of 2, >=2).
REQ-004 SHALL have port clk input 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst input 1, asynchronous active-low reset.
REQ-006 SHALL have ports imem_req_valid output 1, imem_req_addr output ADDR_W, imem_req_ready input 1: fetch request handshake.
REQ-007 SHALL have ports imem_rsp_valid input 1, imem_rsp_data input 32: in-order response, latency >=1 cycle, no backpressure.
REQ-008 SHALL have ports redir_valid input 1, redir_mode input 2, redir_pc input ADDR_W, redir_imm input 26, redir_reg input ADDR_W: redirect request.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_pc output ADDR_W, out_instr output 32: decode handshake.
REQ-010 SHALL have port misalign output 1, one-cycle pulse on misaligned redirect target.

Function
REQ-011 SHALL hold fetch_pc; each accepted request (valid&ready) SHALL advance it by 4, wrapping modulo 2^ADDR_W.
REQ-012 SHALL drive imem_req_valid when queue_count + live_outstanding < DEPTH and redir_valid is low; imem_req_addr = fetch_pc.
REQ-013 SHALL hold imem_req_addr stable while imem_req_valid is high and ready is low.
REQ-014 SHALL write each non-discarded response {request PC, data} into the queue; queue SHALL never overflow under REQ-012.
REQ-015 SHALL present queue head on out_pc/out_instr with out_valid = queue not empty; entry SHALL pop on out_valid&out_ready.
REQ-016 Minimum latency from request accept to out_valid SHALL be response latency + 1 cycle (registered queue).
REQ-017 Redirect target: mode 0 BRANCH = redir_pc+4+(sext(redir_imm[15:0])<<2); mode 1 JUMP = {(redir_pc+4)[ADDR_W-1:28], redir_imm, 2'b00}; mode 2 JR = redir_reg; mode 3 reserved, redirect ignored.
REQ-018 On accepted redirect, the next cycle SHALL have fetch_pc = target with bits[1:0] cleared, queue empty, and discard_count = all outstanding requests (including one accepted that same cycle).
REQ-019 Responses arriving while discard_count > 0, including the redirect cycle, SHALL be dropped, decrementing discard_count.
REQ-020 Output transfer in the redirect cycle SHALL complete; remaining entries SHALL be flushed.
REQ-021 misalign SHALL pulse for one cycle when target[1:0] != 0 on an accepted redirect.
REQ-022 Back-to-back redirects SHALL each be honoured; the last one sets fetch_pc.
REQ-023 Outstanding and discard counters SHALL be clog2(DEPTH)+1 bits wide and never underflow.

Reset
REQ-024 On rst low: fetch_pc = RESET_PC, queue empty, counters 0, imem_req_valid 0, out_valid 0, misalign 0.
REQ-025 Reset mid-operation SHALL abandon in-flight requests; responses after deassertion SHALL be ignored when outstanding = 0.
REQ-026 First request SHALL assert the first cycle after rst deasserts.

Structure
REQ-027 Package fetch_pkg SHALL hold the redir_mode encodings (BRANCH, JUMP, JR, RSVD), INSTR_W = 32 and PC_STEP = 4.
REQ-028 Queue SHALL be the sub-module fetch_fifo (DEPTH entries, synchronous flush, count output); PC and target logic SHALL be in fetch_unit.

Verification
REQ-029 Reset release, ready=1, latency 1, out_ready=1 -> requests 0x0, 0x4, 0x8; out_pc 0x0 with data first appearing 2 cycles after the first accept.
REQ-030 out_ready=0, DEPTH=2 -> exactly 2 requests issued, then imem_req_valid low until a pop.
REQ-031 BRANCH redir_pc=0x100, imm=0xFFFE with 2 outstanding -> both responses dropped; next request 0xFC; next out_pc 0xFC.
REQ-032 JUMP redir_pc=0x1000_0000, imm=0x40 -> next request 0x1000_0100; JR redir_reg=0x203 -> request 0x200 with misalign pulsing once.
REQ-033 Redirect in the same cycle as a response and an out handshake -> response dropped, head transferred, queue empty next cycle.
REQ-034 rst asserted with 2 outstanding, then a stale response -> no out_valid; the next request is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - redir_mode_e : encodings of the redirect target computation
//   - INSTR_W      : instruction word width
//   - PC_STEP      : byte increment between sequential fetches
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,  // pc + 4 + sext(imm16) << 2
        JUMP   = 2'd1,  // {(pc + 4)[top:28], imm26, 2'b00}
        JR     = 2'd2,  // register target
        RSVD   = 2'd3   // reserved, redirect ignored
    } redir_mode_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small output queue between the instruction memory and decode.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   flush      : synchronous clear; a push in the same cycle is dropped
//   push/push_data : write one entry (ignored when full)
//   pop        : remove the head entry (ignored when empty)
//   head_data  : current head entry, valid while !empty
//   empty      : queue holds no entries
//   count      : number of entries held (0..DEPTH)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, collects in-order
// responses into a small queue, and handles branch/jump/register redirects by
// flushing the queue and discarding responses of stale requests.
//   clk, rst                       : clock, asynchronous active-low reset
//   imem_req_valid/addr/ready      : fetch request handshake
//   imem_rsp_valid/data            : in-order response, no backpressure
//   redir_valid/mode/pc/imm/reg    : redirect request and target operands
//   out_valid/ready/pc/instr       : instruction handshake towards decode
//   misalign                       : one-cycle pulse on misaligned redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redir_valid,
    input  logic [1:0]          redir_mode,
    input  logic [ADDR_W-1:0]   redir_pc,
    input  logic [25:0]         redir_imm,
    input  logic [ADDR_W-1:0]   redir_reg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [INSTR_W-1:0]  out_instr,
    output logic                misalign
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int DATA_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] rsp_pc_reg;      // PC belonging to the next kept response
    logic [ADDR_W-1:0] rsp_pc_next;
    logic [CW-1:0]     inflight_reg;    // all requests awaiting a response
    logic [CW-1:0]     inflight_next;
    logic [CW-1:0]     discard_reg;     // oldest in-flight responses to drop
    logic [CW-1:0]     discard_next;
    logic              misalign_reg;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] target_aligned;
    logic              redir_take;
    logic              req_fire;
    logic              rsp_counted;
    logic              rsp_push;
    logic              out_fire;
    logic [CW:0]       occupancy;

    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic [DATA_W-1:0] q_head;

    // ---------------- redirect target ----------------
    assign pc_plus4   = redir_pc + ADDR_W'(PC_STEP);
    assign branch_off = {{(ADDR_W-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};

    always_comb begin
        target = redir_reg;
        case (redir_mode)
            BRANCH:  target = pc_plus4 + branch_off;
            JUMP:    target = {pc_plus4[ADDR_W-1:28], redir_imm, 2'b00};
            JR:      target = redir_reg;
            default: target = redir_reg;
        endcase
    end

    assign target_aligned = {target[ADDR_W-1:2], 2'b00};
    assign redir_take     = redir_valid && (redir_mode != RSVD);

    // ---------------- request side ----------------
    // Stale (to-be-discarded) requests still count towards occupancy so the
    // number in flight never exceeds DEPTH and the counters cannot overflow.
    assign occupancy      = {1'b0, q_count} + {1'b0, inflight_reg};
    assign imem_req_valid = rst && !redir_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // ---------------- response side ----------------
    // A response with nothing in flight belongs to a request abandoned by reset.
    assign rsp_counted = imem_rsp_valid && (inflight_reg != '0);
    assign rsp_push    = rsp_counted && (discard_reg == '0) && !redir_take;
    assign out_fire    = out_valid && out_ready;

    always_comb begin
        inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_counted);

        discard_next = discard_reg;
        if (redir_take) begin
            // Everything still in flight after this edge predates the redirect.
            discard_next = inflight_next;
        end else if (rsp_counted && (discard_reg != '0)) begin
            discard_next = discard_reg - 1'b1;
        end

        fetch_pc_next = fetch_pc_reg;
        if (redir_take) begin
            fetch_pc_next = target_aligned;
        end else if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + ADDR_W'(PC_STEP);
        end

        // Kept responses are for consecutive PCs starting at the last target.
        rsp_pc_next = rsp_pc_reg;
        if (redir_take) begin
            rsp_pc_next = target_aligned;
        end else if (rsp_push) begin
            rsp_pc_next = rsp_pc_reg + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= '0;
            discard_reg  <= '0;
            misalign_reg <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            inflight_reg <= inflight_next;
            discard_reg  <= discard_next;
            misalign_reg <= redir_take && (target[1:0] != 2'b00);
        end
    end

    assign misalign = misalign_reg;

    // ---------------- output queue ----------------
    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir_take),
        .push      (rsp_push),
        .push_data ({rsp_pc_reg, imem_rsp_data}),
        .pop       (out_fire),
        .head_data (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign out_valid = !q_empty;
    assign out_pc    = q_head[DATA_W-1:INSTR_W];
    assign out_instr = q_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural memory answers accepted
// requests in order, a scoreboard queue holds the expected {pc, instr} of
// every request whose instruction should reach decode.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redir_valid;
    logic [1:0]  redir_mode;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_reg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redir_valid    (redir_valid),
        .redir_mode     (redir_mode),
        .redir_pc       (redir_pc),
        .redir_imm      (redir_imm),
        .redir_reg      (redir_reg),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          mis_cnt = 0;
    int          first_acc_cyc = -1;
    int          first_out_cyc = -1;
    logic [31:0] model_pc = RESET_PC;
    logic        mis_exp = 1'b0;
    logic        rsp_en = 1'b0;
    logic        arm_req = 1'b0;
    logic        arm_out = 1'b0;
    logic [31:0] seen_req = 32'hDEAD_BEEF;
    logic [31:0] seen_out = 32'hDEAD_BEEF;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] calc_target(input logic [1:0] mode, input logic [31:0] pc,
                                                input logic [25:0] imm, input logic [31:0] rg);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        case (mode)
            2'd0:    return p4 + {{14{imm[15]}}, imm[15:0], 2'b00};
            2'd1:    return {p4[31:28], imm, 2'b00};
            default: return rg;
        endcase
    endfunction

    // Evaluate what the coming rising edge will do, 1 time unit after the
    // falling edge once inputs have settled.
    task automatic observe();
        exp_t        e;
        logic [31:0] tgt;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            model_pc = RESET_PC;
            mis_exp  = 1'b0;
            return;
        end
        check_eq("misalign", misalign, mis_exp);
        if (misalign) mis_cnt++;
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_unexpected", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_pc", out_pc, e.pc);
                check_eq("out_instr", out_instr, e.instr);
                if (arm_out) begin
                    seen_out = out_pc;
                    arm_out  = 1'b0;
                end
            end
        end
        if (redir_valid) check_eq("req_in_redir", imem_req_valid, 0);
        if (imem_req_valid && imem_req_ready) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            check_eq("req_addr", imem_req_addr, model_pc);
            exp_q.push_back(exp_t'{pc: model_pc, instr: memf(model_pc)});
            pend_q.push_back(imem_req_addr);
            model_pc = model_pc + 32'd4;
            req_cnt++;
            if (arm_req) begin
                seen_req = imem_req_addr;
                arm_req  = 1'b0;
            end
        end
        mis_exp = 1'b0;
        if (redir_valid && redir_mode != 2'd3) begin
            tgt = calc_target(redir_mode, redir_pc, redir_imm, redir_reg);
            exp_q.delete();
            model_pc = {tgt[31:2], 2'b00};
            mis_exp  = (tgt[1:0] != 2'b00);
            arm_req  = 1'b1;
            arm_out  = 1'b1;
            seen_req = 32'hDEAD_BEEF;
            seen_out = 32'hDEAD_BEEF;
        end
    endtask

    task automatic deliver_one();
        if (pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic tick();
        #1;
        observe();
        @(posedge clk);
        @(negedge clk);
        if (rsp_en) deliver_one();
        else imem_rsp_valid = 1'b0;
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        out_ready      = 1'b1;
        rsp_en         = 1'b1;
        redir_valid    = 1'b0;
        repeat (6) tick();
    endtask

    task automatic redirect(input logic [1:0] mode, input logic [31:0] pc,
                            input logic [25:0] imm, input logic [31:0] rg);
        redir_valid = 1'b1;
        redir_mode  = mode;
        redir_pc    = pc;
        redir_imm   = imm;
        redir_reg   = rg;
        tick();
        redir_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redir_valid = 1'b0; redir_mode = '0; redir_pc = '0; redir_imm = '0; redir_reg = '0;
        out_ready = 1'b0;
        @(negedge clk);
        repeat (3) tick();

        // Reset state
        #1;
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_misalign", misalign, 0);

        // Release: ready=1, latency 1, out_ready=1
        rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1; rsp_en = 1'b1;
        #1;
        check_eq("first_req_valid", imem_req_valid, 1);
        check_eq("first_req_addr", imem_req_addr, RESET_PC);
        repeat (12) tick();
        check_eq("first_latency", 64'(first_out_cyc - first_acc_cyc), 2);

        // Queue full with out_ready low: exactly DEPTH requests
        drain();
        req_cnt = 0;
        imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (8) tick();
        check_eq("fill_reqs", req_cnt, DEPTH);
        #1;
        check_eq("stall_valid", imem_req_valid, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check_eq("resume_valid", imem_req_valid, 1);
        drain();

        // BRANCH with two outstanding requests
        rsp_en = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (2) tick();
        rsp_en = 1'b1;
        redirect(2'd0, 32'h100, 26'h000FFFE, 32'h0);
        repeat (8) tick();
        check_eq("branch_req", seen_req, 32'hFC);
        check_eq("branch_out", seen_out, 32'hFC);
        drain();

        // JUMP, reserved mode, then misaligned JR
        imem_req_ready = 1'b1;
        redirect(2'd1, 32'h1000_0000, 26'h40, 32'h0);
        repeat (6) tick();
        check_eq("jump_req", seen_req, 32'h1000_0100);
        check_eq("jump_out", seen_out, 32'h1000_0100);
        redirect(2'd3, 32'h501, 26'h3, 32'h7);
        repeat (4) tick();
        mis_cnt = 0;
        redirect(2'd2, 32'h0, 26'h0, 32'h203);
        repeat (6) tick();
        check_eq("jr_req", seen_req, 32'h200);
        check_eq("jr_misalign_pulses", mis_cnt, 1);
        drain();

        // Redirect together with a response and an output transfer
        rsp_en = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b0;
        repeat (2) tick();
        imem_req_ready = 1'b0;
        deliver_one();
        tick();
        deliver_one();
        out_ready = 1'b1;
        redirect(2'd2, 32'h0, 26'h0, 32'h300);
        imem_rsp_valid = 1'b0;
        #1;
        check_eq("flush_empty", out_valid, 0);
        imem_req_ready = 1'b1; rsp_en = 1'b1;
        repeat (8) tick();
        check_eq("flush_next_out", seen_out, 32'h300);
        drain();

        // Reset with two outstanding, then stale responses
        rsp_en = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (2) tick();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_req_valid", imem_req_valid, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        repeat (2) tick();
        rst = 1'b1; rsp_en = 1'b1;
        #1;
        check_eq("post_rst_req_valid", imem_req_valid, 1);
        repeat (4) begin
            tick();
            check_eq("stale_out_valid", out_valid, 0);
        end
        imem_req_ready = 1'b1;
        arm_req = 1'b1; seen_req = 32'hDEAD_BEEF;
        repeat (6) tick();
        check_eq("post_rst_req", seen_req, RESET_PC);

        drain();
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
